// File: rtl/maj_pkg.sv
// ----------------------------------------------------------------------------
// maj_pkg
// Shared definitions for the 16-bit majority voter and its sampling front end.
//   MAJ_WIDTH : samples per window / voter input width
//   FILL_W    : width of the partial-window sample counter
//   state_t   : status FSM encoding of the sample window block
// ----------------------------------------------------------------------------
package maj_pkg;

    localparam int MAJ_WIDTH = 16;
    localparam int FILL_W    = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        FULL_WAIT = 2'd2
    } state_t;

endpackage : maj_pkg

// File: rtl/maj_sample_tick.sv
// ----------------------------------------------------------------------------
// maj_sample_tick
// Sample-rate prescaler. Counts enabled cycles 0..DIV-1 and raises tick in the
// cycle where the count sits at DIV-1, so the first tick lands on the DIV-th
// enabled cycle. Dropping en restarts the count from 0 on the next edge.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   en   : sampling enable; low restarts the prescaler
//   tick : sample strobe (combinational, qualified by en)
// ----------------------------------------------------------------------------
module maj_sample_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int          PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic [PW-1:0] cnt_q;

    assign tick = en && (cnt_q == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule : maj_sample_tick

// File: rtl/maj16_sample_window.sv
// ----------------------------------------------------------------------------
// maj16_sample_window
// Oversamples a serial input, assembles WIDTH consecutive samples into a word
// and offers it on a double-buffered valid/ready output for the majority voter.
// A window that completes while the previous one is still unconsumed is dropped
// and recorded in the sticky overrun flag.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | en low; prescaler and fill held at 0
//   FILL      | collecting samples into the current window
//   FULL_WAIT | window just dropped because the output was still occupied
//
// The FSM only reports status; the datapath follows its own rules below.
//
// Ports:
//   clk     : clock
//   rst     : asynchronous active-high reset
//   din     : serial sample input, already synchronised to clk
//   en      : sampling enable
//   clr_ovr : synchronous clear of overrun
//   Data    : completed window, bit WIDTH-1 oldest sample, bit 0 newest
//   valid   : Data holds an unconsumed window
//   ready   : downstream accepts Data this cycle
//   overrun : sticky, a completed window was dropped
//   fill    : samples in the current partial window
// ----------------------------------------------------------------------------
module maj16_sample_window
    import maj_pkg::*;
#(
    parameter int WIDTH = MAJ_WIDTH,
    parameter int DIV   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              en,
    input  logic              clr_ovr,
    output logic [WIDTH-1:0]  Data,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);

    logic             tick;
    logic             last_tick;
    logic             blocked;
    logic             load;
    logic             drop;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word;
    state_t           state_q;
    state_t           state_d;

    maj_sample_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Word as it will look once the current sample is shifted in.
    assign word      = {shift_q[WIDTH-2:0], din};
    assign last_tick = tick && (fill == FILL_LAST);

    // Output register is occupied and not being drained this cycle.
    assign blocked   = valid && !ready;
    assign load      = last_tick && !blocked;
    assign drop      = last_tick && blocked;

    // The shift register is never cleared by en; a fresh window always
    // replaces every bit before it can complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else if (tick) begin
            shift_q <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else if (!en) begin
            fill <= '0;
        end else if (tick) begin
            fill <= last_tick ? '0 : fill + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Data <= '0;
        end else if (load) begin
            Data <= word;
        end
    end

    // A completion with ready high reloads in the same cycle, so back-to-back
    // windows never leave a bubble on valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // A new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = FILL;
                FILL:      state_d = drop ? FULL_WAIT : FILL;
                FULL_WAIT: state_d = drop ? FULL_WAIT : FILL;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule : maj16_sample_window

// File: tb/tb_maj16_sample_window.sv
// ----------------------------------------------------------------------------
// tb_maj16_sample_window
// Two instances (DIV=4 and DIV=1) share one set of inputs. A window-level
// reference model tracks enabled-cycle counts, collected samples and the
// output buffer for each instance; outputs are compared every cycle, plus
// directed checks on the scenario-specific values.
// ----------------------------------------------------------------------------
module tb_maj16_sample_window;

    localparam int W = 16;

    logic         clk     = 1'b0;
    logic         rst     = 1'b0;
    logic         din     = 1'b0;
    logic         en      = 1'b0;
    logic         ready   = 1'b0;
    logic         clr_ovr = 1'b0;

    logic [W-1:0] data4, data1;
    logic         valid4, valid1;
    logic         ovr4, ovr1;
    logic [4:0]   fill4, fill1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    maj16_sample_window #(.WIDTH(W), .DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr_ovr(clr_ovr),
        .Data(data4), .valid(valid4), .ready(ready), .overrun(ovr4), .fill(fill4)
    );

    maj16_sample_window #(.WIDTH(W), .DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr_ovr(clr_ovr),
        .Data(data1), .valid(valid1), .ready(ready), .overrun(ovr1), .fill(fill1)
    );

    // ------------------------------------------------------------------
    // Reference model: index 0 -> DIV=4, index 1 -> DIV=1
    // ------------------------------------------------------------------
    int div_m   [2] = '{4, 1};
    int ecnt    [2];
    int nsamp   [2];
    int samp    [2][W];
    int m_data  [2];
    int m_valid [2];
    int m_ovr   [2];

    function automatic void model_reset_all();
        for (int i = 0; i < 2; i++) begin
            ecnt[i]    = 0;
            nsamp[i]   = 0;
            m_data[i]  = 0;
            m_valid[i] = 0;
            m_ovr[i]   = 0;
        end
    endfunction

    function automatic void model_step(input int i);
        int word;
        bit done;
        bit lost;
        word = 0;
        done = 0;
        if (en) begin
            ecnt[i] = ecnt[i] + 1;
            if (ecnt[i] % div_m[i] == 0) begin
                samp[i][nsamp[i]] = int'(din);
                nsamp[i] = nsamp[i] + 1;
                if (nsamp[i] == W) begin
                    for (int b = 0; b < W; b++) word = word * 2 + samp[i][b];
                    done     = 1;
                    nsamp[i] = 0;
                end
            end
        end else begin
            ecnt[i]  = 0;
            nsamp[i] = 0;
        end
        lost = done && (m_valid[i] == 1) && !ready;
        if (done && !lost) begin
            m_data[i]  = word;
            m_valid[i] = 1;
        end else if ((m_valid[i] == 1) && ready) begin
            m_valid[i] = 0;
        end
        if (lost)         m_ovr[i] = 1;
        else if (clr_ovr) m_ovr[i] = 0;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("d4.data",  int'(data4),  m_data[0]);
        check("d4.valid", int'(valid4), m_valid[0]);
        check("d4.ovr",   int'(ovr4),   m_ovr[0]);
        check("d4.fill",  int'(fill4),  nsamp[0]);
        check("d1.data",  int'(data1),  m_data[1]);
        check("d1.valid", int'(valid1), m_valid[1]);
        check("d1.ovr",   int'(ovr1),   m_ovr[1]);
        check("d1.fill",  int'(fill1),  nsamp[1]);
    endtask

    // One clock: model sees the same pre-edge inputs as the DUT, outputs are
    // compared 1 ns after the edge. Inputs are changed by the caller after return.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset_all();
        else for (int i = 0; i < 2; i++) model_step(i);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1 model_reset_all();
        compare_all();
        check("rst.data",  int'(data4),  0);
        check("rst.valid", int'(valid4), 0);
        check("rst.ovr",   int'(ovr4),   0);
        check("rst.fill",  int'(fill4),  0);
    endtask

    int pulses;
    int saved;

    initial begin
        // power-on reset
        #1 rst = 1'b1;
        #1 model_reset_all();
        compare_all();
        step();
        step();
        rst = 1'b0;
        step();

        // first window: 9 ones then 7 zeros at DIV=4
        en     = 1'b1;
        ready  = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 64; k++) begin
            din = ((k - 1) / 4 < 9);
            step();
            if (valid4) pulses++;
        end
        check("ff80.pulses", pulses, 1);
        check("ff80.valid",  int'(valid4), 1);
        check("ff80.data",   int'(data4), 16'hFF80);

        // back-to-back windows with ready held high
        for (int k = 65; k <= 192; k++) begin
            din = 1'($urandom_range(0, 1));
            step();
            check("b2b.valid", int'(valid4), (k % 64 == 0) ? 1 : 0);
        end
        check("b2b.ovr", int'(ovr4), 0);

        // drain the 192 window, then hold ready low across two completions
        din = 1'($urandom_range(0, 1));
        step();
        ready = 1'b0;
        saved = 0;
        for (int k = 194; k <= 320; k++) begin
            din = 1'($urandom_range(0, 1));
            step();
            if (k == 256) saved = m_data[0];
            if (k == 256) check("ovr.first", int'(ovr4), 0);
        end
        check("ovr.set",  int'(ovr4),  1);
        check("ovr.keep", int'(data4), saved);

        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("clr.ovr",   int'(ovr4),   0);
        check("clr.data",  int'(data4),  saved);
        check("clr.valid", int'(valid4), 1);

        // drop en at fill=10 while a window is pending, drain it during en=0
        for (int g = 0; g < 200 && nsamp[0] != 10; g++) begin
            din = 1'($urandom_range(0, 1));
            step();
        end
        check("endrop.fill10", int'(fill4), 10);
        en = 1'b0;
        step();
        check("endrop.fill0", int'(fill4),  0);
        check("endrop.pend",  int'(valid4), 1);
        ready = 1'b1;
        step();
        check("endrop.drain", int'(valid4), 0);
        step();

        en = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            din = 1'($urandom_range(0, 1));
            step();
            if (k == 63) check("reen.early", int'(valid4), 0);
        end
        check("reen.valid", int'(valid4), 1);

        // hold the next window pending and stop mid-fill at 7, then reset
        ready = 1'b0;
        for (int g = 0; g < 100 && nsamp[0] != 7; g++) begin
            din = 1'($urandom_range(0, 1));
            step();
        end
        check("mid.fill",  int'(fill4),  7);
        check("mid.valid", int'(valid4), 1);
        async_reset();
        step();
        step();

        // release with DIV=1 alternating input; DIV=4 must not tick early
        rst   = 1'b0;
        en    = 1'b1;
        ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            din = k[0];
            step();
            if (k == 3) check("rel.notick", int'(fill4), 0);
            if (k == 4) check("rel.tick",   int'(fill4), 1);
            if (k < 16) check("div1.fill",  int'(fill1), k);
        end
        check("div1.valid", int'(valid1), 1);
        check("div1.data",  int'(data1),  16'hAAAA);
        check("div1.wrap",  int'(fill1),  0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            din     = 1'($urandom_range(0, 1));
            en      = ($urandom_range(0, 499) != 0);
            ready   = ((c / 150) % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            clr_ovr = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_maj16_sample_window
